hrange_arbiter: RTL
===================

// Module: hrange_arbiter
// PURPOSE
// Shares one hrange generator instance between NUM_REQ requesters.
// - Captures each requester's start pulse and arguments (base, limit, step).
// - Grants the generator round-robin and launches it with the stored arguments.
// - Routes the generator's value stream and backpressure to and from the owning requester only.
// - Sits between caller FSMs and a single hrange instance; the two share _clock and _reset.
// PARAMETERS
// NUM_REQ  2   number of requesters (>=2)
// DATA_W   32  signed width of base/limit/step/_0
// PORTS
// _clock        in   1                clock, all logic on rising edge
// _reset        in   1                synchronous, active-high reset
// req_start     in   NUM_REQ          per-requester one-cycle start pulse
// req_base      in   NUM_REQ*DATA_W   args; sampled only in the req_start cycle
// req_limit     in   NUM_REQ*DATA_W
// req_step      in   NUM_REQ*DATA_W
// req_wait      in   NUM_REQ          per-requester backpressure (1 = hold output)
// req_ready     out  NUM_REQ          1 = requester idle (nothing pending or running)
// req_valid     out  NUM_REQ          value valid to that requester
// req_done      out  NUM_REQ          one-cycle pulse when that requester's job ends
// req_0         out  DATA_W           generator value (shared bus, qualify with req_valid)
// gen_start     out  1                to hrange _start
// gen_base/gen_limit/gen_step  out  DATA_W  to hrange args, valid while gen_start=1
// gen_wait      out  1                to hrange _wait
// gen_ready     in   1                from hrange _ready
// gen_valid     in   1                from hrange _valid
// gen_0         in   DATA_W           from hrange _0
// BEHAVIOUR
// - Reset: state=IDLE, pending=0, rr_ptr=0, owner=0.
//   Outputs after reset: req_ready=all 1, req_valid=0, req_done=0, gen_start=0, gen_wait=0, gen_* args=0, req_0=0.
// - Capture: req_start[i] with req_ready[i]=1 latches args into slot i and sets pending[i]; req_ready[i] falls the next cycle.
//   req_start[i] with req_ready[i]=0 is ignored; slot i is unchanged.
// - Simultaneous starts from several requesters: all are captured in the same cycle.
// - FSM states:
//   IDLE:   any pending -> pick the first pending index at or after rr_ptr (circular) -> owner; LAUNCH.
//   LAUNCH: exactly one cycle; gen_start=1 with owner slot args; clear pending[owner] -> RUN.
//   RUN:    req_valid[owner]=gen_valid; req_0=gen_0; gen_wait=req_wait[owner]; other req_valid=0.
//           gen_ready=1 in RUN -> DONE. The cycle with gen_ready=1 still forwards gen_valid/gen_0.
//   DONE:   req_done[owner]=1 for one cycle; rr_ptr=owner+1 mod NUM_REQ; req_ready[owner]=1 next cycle; -> IDLE.
// - Latency: capture -> gen_start is 2 cycles when idle (capture edge, IDLE pick, LAUNCH).
//   DONE -> next LAUNCH is 2 cycles.
// - Outside RUN: gen_wait=0 and all req_valid=0.
// - The owner may re-request in its DONE cycle; the request is ignored (req_ready still 0).
// - Reset mid-RUN: everything returns to reset values in the next cycle; in-flight jobs and pending slots are discarded.
//   No req_done is issued for discarded jobs.
// - Arithmetic: none on data; args pass through unmodified as signed DATA_W. rr_ptr is $clog2(NUM_REQ) bits with explicit wrap.
// STRUCTURE
// - Package hrange_arb_pkg: state enum {IDLE,LAUNCH,RUN,DONE}, DATA_W default, arg-slot struct {base,limit,step}.
// - Sub-module rr_picker: combinational round-robin select (pending vector + ptr -> index + any).
// - hrange_arbiter holds the slots, FSM and muxing.
// TESTING (bench instantiates hrange_arbiter + real hrange)
// 1. Req0 start (0,10,2), wait=0
//    -> req_valid[0] carries 0,2,4,6,8; req_done[0] pulses once; req_valid[1] stays 0; req_ready[0] returns to 1.
// 2. Req0 (0,10,2) and req1 (5,8,1) start in the same cycle, rr_ptr=0
//    -> req0 stream 0..8 completes, then req1 stream 5,6,7; exactly one gen_start per job.
// 3. Fairness: both requesters re-request at every req_done, 4 jobs -> owner order 0,1,0,1.
// 4. Backpressure: job (0,10,2), req_wait[0]=1 for 3 cycles after first value
//    -> gen_wait=1 for those cycles; value 0 held, no value lost or repeated.
// 5. Req0 start pulsed again during its RUN -> ignored; exactly one stream and one req_done.
// 6. Reset asserted mid-RUN (after value 4)
//    -> next cycle all outputs at reset values; no req_done; a fresh req1 (1,4,1) then yields 1,2,3.

Source files
------------

// File: rtl/hrange_arb_pkg.sv
// Shared types for the hrange arbiter: FSM state encoding, default data width,
// argument-slot layout and the round-robin pointer wrap helper.
package hrange_arb_pkg;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic signed [DEF_DATA_W-1:0] base;
        logic signed [DEF_DATA_W-1:0] limit;
        logic signed [DEF_DATA_W-1:0] step;
    } arg_slot_t;

    // Pointer advance with explicit wrap, so non-power-of-two counts stay in range.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/hrange_arbiter_rr_picker.sv
// Combinational round-robin select: first set bit of pending at or after ptr,
// scanning circularly.
module rr_picker
    import hrange_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        // Scan from the far end so the closest index to ptr wins last.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (pending[j]) begin
                any = 1'b1;
                idx = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/hrange_arbiter.sv
// Shares a single hrange generator between NUM_REQ requesters: latches start
// arguments per requester, grants round-robin, and routes the value stream.
//
// state  | meaning
// IDLE   | no job running; pick next pending requester
// LAUNCH | one-cycle gen_start with the owner's stored args
// RUN    | generator owned; stream and backpressure routed to owner
// DONE   | one-cycle req_done to owner; advance round-robin pointer
module hrange_arbiter
    import hrange_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      _clock,
    input  logic                      _reset,
    input  logic [NUM_REQ-1:0]        req_start,
    input  logic [NUM_REQ*DATA_W-1:0] req_base,
    input  logic [NUM_REQ*DATA_W-1:0] req_limit,
    input  logic [NUM_REQ*DATA_W-1:0] req_step,
    input  logic [NUM_REQ-1:0]        req_wait,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         req_0,
    output logic                      gen_start,
    output logic [DATA_W-1:0]         gen_base,
    output logic [DATA_W-1:0]         gen_limit,
    output logic [DATA_W-1:0]         gen_step,
    output logic                      gen_wait,
    input  logic                      gen_ready,
    input  logic                      gen_valid,
    input  logic [DATA_W-1:0]         gen_0
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic signed [DATA_W-1:0] base;
        logic signed [DATA_W-1:0] limit;
        logic signed [DATA_W-1:0] step;
    } slot_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] capture;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;
    slot_t              slots [NUM_REQ];

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .pending (pending),
        .ptr     (rr_ptr),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    // A requester is busy from capture until the cycle after its DONE.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !pending[i] && !((state != IDLE) && (owner == PTR_W'(i)));
        end
    end

    assign capture = req_start & req_ready;

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state   <= IDLE;
            pending <= '0;
            rr_ptr  <= '0;
            owner   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_any) begin
                owner <= pick_idx;
            end
            if (state == DONE) begin
                rr_ptr <= PTR_W'(rr_next(int'(owner), NUM_REQ));
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (capture[i]) begin
                    pending[i] <= 1'b1;
                end else if (state == LAUNCH && owner == PTR_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Argument storage needs no reset: it is only read after a capture wrote it.
    always_ff @(posedge _clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (capture[i]) begin
                slots[i].base  <= req_base[i*DATA_W +: DATA_W];
                slots[i].limit <= req_limit[i*DATA_W +: DATA_W];
                slots[i].step  <= req_step[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_valid = '0;
        req_done  = '0;
        req_0     = '0;
        gen_start = 1'b0;
        gen_base  = '0;
        gen_limit = '0;
        gen_step  = '0;
        gen_wait  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                gen_start = 1'b1;
                gen_base  = slots[owner].base;
                gen_limit = slots[owner].limit;
                gen_step  = slots[owner].step;
                state_nxt = RUN;
            end
            RUN: begin
                req_valid[owner] = gen_valid;
                req_0            = gen_0;
                gen_wait         = req_wait[owner];
                if (gen_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                req_done[owner] = 1'b1;
                state_nxt       = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
